uart_tx_core: RTL and testbench

//  Serial transmit engine driven by the UART register block's tx_data/cfg/ctrl outputs.

---
 rtl/uart_tx_core.sv | 199 +++++++++++++++++++
 tb/tb_uart_tx_core.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// UART serial transmit engine: start bit, 5-8 data bits LSB first, optional parity, 1-2 stop bits.
// Define UART_TX_BREAK_EN to add the tx_break input and the BREAK line-hold state.
module uart_tx_core #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic [1:0] data_bit_num,
    input  logic       stop_bit_num,
    input  logic       parity_en,
    input  logic       parity_type,
    input  logic       start_tx,
`ifdef UART_TX_BREAK_EN
    input  logic       tx_break,
`endif
    output logic       start_tx_re_cfg,
    output logic       tx_done,
    output logic       tx
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef UART_TX_BREAK_EN
        ,
        S_BREAK
`endif
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_nxt;
    logic [2:0]       bit_cnt, bit_cnt_nxt;
    logic             tx_nxt, tx_done_nxt, ack_nxt;
    logic             load_shadow;

    logic [7:0]       sh_data;
    logic [2:0]       sh_last_bit;
    logic             sh_stop2;
    logic             sh_par_en;
    logic             sh_par_type;

    logic             baud_last;
    logic [2:0]       bit_inc;
    logic             parity_bit;

    assign baud_last  = (baud_cnt == BAUD_LAST);
    assign bit_inc    = bit_cnt + 3'd1;
    // Payload bits above the frame width are cleared at load, so a full XOR gives the parity.
    assign parity_bit = (^sh_data) ^ sh_par_type;

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_nxt    = state;
        baud_cnt_nxt = baud_last ? '0 : baud_cnt + CNT_W'(1);
        bit_cnt_nxt  = bit_cnt;
        tx_nxt       = tx;
        tx_done_nxt  = tx_done;
        ack_nxt      = 1'b0;
        load_shadow  = 1'b0;

        case (state)
            S_IDLE: begin
                tx_nxt       = 1'b1;
                tx_done_nxt  = 1'b1;
                baud_cnt_nxt = '0;
                bit_cnt_nxt  = '0;
                if (start_tx) begin
                    load_shadow = 1'b1;
                    state_nxt   = S_START;
                    tx_nxt      = 1'b0;
                    tx_done_nxt = 1'b0;
                    ack_nxt     = 1'b1;
                end
`ifdef UART_TX_BREAK_EN
                else if (tx_break) begin
                    state_nxt   = S_BREAK;
                    tx_nxt      = 1'b0;
                    tx_done_nxt = 1'b0;
                end
`endif
            end

            S_START: begin
                if (baud_last) begin
                    state_nxt   = S_DATA;
                    bit_cnt_nxt = '0;
                    tx_nxt      = sh_data[0];
                end
            end

            S_DATA: begin
                if (baud_last) begin
                    if (bit_cnt == sh_last_bit) begin
                        bit_cnt_nxt = '0;
                        if (sh_par_en) begin
                            state_nxt = S_PARITY;
                            tx_nxt    = parity_bit;
                        end else begin
                            state_nxt = S_STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        bit_cnt_nxt = bit_inc;
                        tx_nxt      = sh_data[bit_inc];
                    end
                end
            end

            S_PARITY: begin
                if (baud_last) begin
                    state_nxt   = S_STOP;
                    bit_cnt_nxt = '0;
                    tx_nxt      = 1'b1;
                end
            end

            S_STOP: begin
                tx_nxt = 1'b1;
                if (baud_last) begin
                    if (sh_stop2 && (bit_cnt == 3'd0)) begin
                        bit_cnt_nxt = 3'd1;
                    end else begin
                        state_nxt   = S_IDLE;
                        bit_cnt_nxt = '0;
                        tx_done_nxt = 1'b1;
                    end
                end
            end

`ifdef UART_TX_BREAK_EN
            // bit_cnt 0: line held low while tx_break stays high; bit_cnt 1: one bit time of mark.
            S_BREAK: begin
                if (bit_cnt == 3'd0) begin
                    baud_cnt_nxt = '0;
                    if (!tx_break) begin
                        bit_cnt_nxt = 3'd1;
                        tx_nxt      = 1'b1;
                    end else begin
                        tx_nxt = 1'b0;
                    end
                end else begin
                    tx_nxt = 1'b1;
                    if (baud_last) begin
                        state_nxt   = S_IDLE;
                        bit_cnt_nxt = '0;
                        tx_done_nxt = 1'b1;
                    end
                end
            end
`endif

            default: begin
                state_nxt    = S_IDLE;
                baud_cnt_nxt = '0;
                bit_cnt_nxt  = '0;
                tx_nxt       = 1'b1;
                tx_done_nxt  = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; the combinational block above uses blocking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            baud_cnt        <= '0;
            bit_cnt         <= '0;
            tx              <= 1'b1;
            tx_done         <= 1'b1;
            start_tx_re_cfg <= 1'b0;
        end else begin
            state           <= state_nxt;
            baud_cnt        <= baud_cnt_nxt;
            bit_cnt         <= bit_cnt_nxt;
            tx              <= tx_nxt;
            tx_done         <= tx_done_nxt;
            start_tx_re_cfg <= ack_nxt;
        end
    end

    // NOTE: shadow registers carry no reset; they are only read after a start has loaded them.
    always_ff @(posedge clk) begin
        if (load_shadow) begin
            sh_data     <= tx_data & (8'hFF >> (2'd3 - data_bit_num));
            sh_last_bit <= {1'b1, data_bit_num};
            sh_stop2    <= stop_bit_num;
            sh_par_en   <= parity_en;
            sh_par_type <= parity_type;
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Scoreboard bench for uart_tx_core at BAUD_DIV=4: stimulus queues expected frames, a monitor checks the line.
module tb_uart_tx_core;

    localparam int BAUD = 4;

    typedef struct {
        logic [11:0] bits;
        int          nbits;
    } frame_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] tx_data = '0;
    logic [1:0] data_bit_num = '0;
    logic       stop_bit_num = 1'b0;
    logic       parity_en = 1'b0;
    logic       parity_type = 1'b0;
    logic       start_tx = 1'b0;
    logic       tx_break = 1'b0;
    logic       start_tx_re_cfg;
    logic       tx_done;
    logic       tx;

    int         errors = 0;
    int         checks = 0;
    frame_t     exp_q[$];
    bit         in_break = 1'b0;
    bit         mon_busy = 1'b0;

    uart_tx_core #(.BAUD_DIV(BAUD)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .tx_data         (tx_data),
        .data_bit_num    (data_bit_num),
        .stop_bit_num    (stop_bit_num),
        .parity_en       (parity_en),
        .parity_type     (parity_type),
        .start_tx        (start_tx),
`ifdef UART_TX_BREAK_EN
        .tx_break        (tx_break),
`endif
        .start_tx_re_cfg (start_tx_re_cfg),
        .tx_done         (tx_done),
        .tx              (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference frame: start, N payload bits LSB first, parity from the count of ones, stop bits.
    function automatic frame_t model(input logic [7:0] d, input logic [1:0] dbn, input logic sb,
                                     input logic pe, input logic pt);
        frame_t f;
        int n;
        int ones;
        int idx;
        n      = 5 + int'(dbn);
        ones   = 0;
        idx    = 0;
        f.bits = '0;
        f.bits[idx] = 1'b0;
        idx = idx + 1;
        for (int i = 0; i < n; i++) begin
            f.bits[idx] = d[i];
            ones = ones + int'(d[i]);
            idx = idx + 1;
        end
        if (pe) begin
            f.bits[idx] = ((ones % 2) == 1) ^ pt;
            idx = idx + 1;
        end
        for (int s = 0; s < 1 + int'(sb); s++) begin
            f.bits[idx] = 1'b1;
            idx = idx + 1;
        end
        f.nbits = idx;
        return f;
    endfunction

    // Drives a start request like the register block: start_tx holds until the cycle after the acknowledge.
    task automatic send(input logic [7:0] d, input logic [1:0] dbn, input logic sb,
                        input logic pe, input logic pt);
        bit got;
        tx_data      = d;
        data_bit_num = dbn;
        stop_bit_num = sb;
        parity_en    = pe;
        parity_type  = pt;
        exp_q.push_back(model(d, dbn, sb, pe, pt));
        start_tx = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (start_tx_re_cfg) begin
                got = 1'b1;
                break;
            end
        end
        check("start_ack_seen", int'(got), 1);
        @(negedge clk);
        start_tx = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_done && !mon_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_reached", int'(ok), 1);
    endtask

    // Monitor: each tx_done fall opens a frame, which is compared bit by bit with the queued expectation.
    initial begin : monitor
        bit     prev_done;
        frame_t exp;
        int     bad[12];
        int     ack_cycles;
        int     done_high;
        bit     ack_first;
        bit     aborted;
        int     k;
        prev_done = 1'b1;
        forever begin
            @(negedge clk);
            if (reset_n && !in_break && prev_done && !tx_done) begin
                mon_busy = 1'b1;
                check("frame_queued", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp = exp_q.pop_front();
                    for (int b = 0; b < 12; b++) bad[b] = 0;
                    ack_cycles = 0;
                    done_high  = 0;
                    ack_first  = start_tx_re_cfg;
                    aborted    = 1'b0;
                    for (int c = 0; c < exp.nbits * BAUD; c++) begin
                        if (c > 0) @(negedge clk);
                        if (!reset_n) begin
                            aborted = 1'b1;
                            break;
                        end
                        k = c / BAUD;
                        if (tx !== exp.bits[k]) bad[k]++;
                        if (start_tx_re_cfg) ack_cycles++;
                        if (tx_done) done_high++;
                    end
                    if (!aborted) begin
                        for (int b = 0; b < exp.nbits; b++)
                            check($sformatf("bit%0d_wrong_samples(exp=%0d)", b, exp.bits[b]), bad[b], 0);
                        check("ack_in_first_cycle", int'(ack_first), 1);
                        check("ack_cycles", ack_cycles, 1);
                        check("tx_done_high_inside_frame", done_high, 0);
                        @(negedge clk);
                        if (reset_n) begin
                            check("tx_done_after_frame", int'(tx_done), 1);
                            check("tx_idle_after_frame", int'(tx), 1);
                        end
                    end
                end
                mon_busy = 1'b0;
            end
            prev_done = tx_done;
        end
    end

    initial begin : stimulus
        int bad_cycles;
        int gap;
        bit ok;
        #3 reset_n = 1'b0;
        #1;
        check("reset_tx", int'(tx), 1);
        check("reset_tx_done", int'(tx_done), 1);
        check("reset_ack", int'(start_tx_re_cfg), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_tx", int'(tx), 1);
        check("idle_tx_done", int'(tx_done), 1);

        // 8N1 0x55, 5E2 0xFF, 7O1 0x00
        send(8'h55, 2'd3, 1'b0, 1'b0, 1'b0);
        wait_idle();
        send(8'hFF, 2'd0, 1'b1, 1'b1, 1'b0);
        wait_idle();
        send(8'h00, 2'd2, 1'b0, 1'b1, 1'b1);
        wait_idle();

        // Inputs changed mid-frame must not disturb the frame in flight.
        send(8'h55, 2'd3, 1'b0, 1'b0, 1'b0);
        tx_data      = 8'hAA;
        data_bit_num = 2'd0;
        stop_bit_num = 1'b1;
        parity_en    = 1'b1;
        parity_type  = 1'b1;
        wait_idle();
        send(8'hAA, 2'd3, 1'b0, 1'b0, 1'b0);

        // Back-to-back: the next request is already pending while the previous frame runs.
        send(8'h3C, 2'd1, 1'b1, 1'b1, 1'b1);
        wait_idle();

        for (int f = 0; f < 24; f++) begin
            send(8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                tx_data      = 8'($urandom);
                data_bit_num = 2'($urandom_range(0, 3));
                stop_bit_num = 1'($urandom_range(0, 1));
                parity_en    = 1'($urandom_range(0, 1));
                parity_type  = 1'($urandom_range(0, 1));
            end
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                wait_idle();
                repeat (gap - 1) @(negedge clk);
            end
        end
        wait_idle();

        // Reset around cycle 10 of a frame aborts it at once, and the line stays quiet afterwards.
        send(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midframe_reset_tx", int'(tx), 1);
        check("midframe_reset_tx_done", int'(tx_done), 1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        bad_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!tx || !tx_done || start_tx_re_cfg) bad_cycles++;
        end
        check("quiet_after_reset", bad_cycles, 0);
        send(8'h96, 2'd3, 1'b1, 1'b1, 1'b0);
        wait_idle();

`ifdef UART_TX_BREAK_EN
        begin
            int low_cnt;
            int mark_cnt;
            in_break = 1'b1;
            low_cnt  = 0;
            mark_cnt = 0;
            tx_break = 1'b1;
            for (int i = 1; i <= 60; i++) begin
                @(negedge clk);
                if (!tx && !tx_done) low_cnt++;
                else if (tx && !tx_done) mark_cnt++;
                if (i == 20) tx_break = 1'b0;
                if (tx_done && mark_cnt > 0) break;
            end
            check("break_low_cycles", low_cnt, 20);
            check("break_mark_cycles", mark_cnt, BAUD);
            check("break_done_restored", int'(tx_done), 1);
            @(negedge clk);
            in_break = 1'b0;
        end
`endif

        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mon_busy && tx_done) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_timeout", int'(ok), 1);
        check("scoreboard_left", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
